// File: rtl/dmem_ahb_slave.sv
// AHB-Lite data-memory responder for the core's data port.
// Single-port word SRAM with byte-lane writes, optional wait states,
// read-after-write forwarding and a two-cycle ERROR response.
// Payloads are right-justified; the core performs sign/zero extension.
module dmem_ahb_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          ADDR_W      = 14,
    parameter int          WAIT_STATES = 0
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA_D
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DATA = 3'd1,
        S_WAIT = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    // Byte-lane mask for an access of the given size at byte offset lo.
    function automatic logic [31:0] f_lane_mask(input logic [2:0] size, input logic [1:0] lo);
        logic [31:0] m;
        case (size)
            3'd0:    m = 32'h0000_00FF;
            3'd1:    m = 32'h0000_FFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m << {lo, 3'b000};
    endfunction

    // Right-justify the addressed lanes of a word and clear the unused upper bits.
    function automatic logic [31:0] f_extract(input logic [31:0] word, input logic [2:0] size,
                                              input logic [1:0] lo);
        logic [31:0] m;
        case (size)
            3'd0:    m = 32'h0000_00FF;
            3'd1:    m = 32'h0000_FFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        return (word >> {lo, 3'b000}) & m;
    endfunction

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic [ADDR_W-1:0]   r_idx;
    logic [1:0]          r_lo;
    logic [2:0]          r_size;
    logic                r_write;
    logic                r_hreadyout;
    logic                r_hresp;
    logic [31:0]         r_hrdata;
    logic [31:0]         r_mem [2**ADDR_W];

    state_t              w_next;
    logic [3:0]          w_cnt_next;
    logic [31:0]         w_offset;
    logic                w_in_range;
    logic                w_misalign;
    logic                w_err;
    logic                w_accept;
    logic                w_commit;
    logic [31:0]         w_wmask;
    logic [31:0]         w_merged;
    logic [ADDR_W-1:0]   w_src_idx;
    logic [1:0]          w_src_lo;
    logic [2:0]          w_src_size;
    logic [31:0]         w_src_word;
    logic                w_load;
    logic                w_unused_htrans0;

    assign w_unused_htrans0 = HTRANS[0];
    assign w_offset   = HADDR - BASE_ADDR;
    assign w_in_range = (w_offset[31:ADDR_W+2] == {(30-ADDR_W){1'b0}});
    assign w_err      = (HSIZE > 3'd2) || w_misalign || !w_in_range;
    // Only accept while our own data phase is completing, so a stalled bus never double-accepts.
    assign w_accept   = HSEL && HTRANS[1] && HREADY && r_hreadyout;
    // A store commits on the edge that ends its data phase; reset on that edge drops it.
    assign w_commit   = (r_state == S_DATA) && r_write && !RES;
    assign w_wmask    = f_lane_mask(r_size, r_lo);
    assign w_merged   = (r_mem[r_idx] & ~w_wmask) | ((HWDATA << {r_lo, 3'b000}) & w_wmask);

    // Alignment check for the address phase access size.
    always_comb begin
        w_misalign = 1'b0;
        case (HSIZE)
            3'd1:    w_misalign = HADDR[0];
            3'd2:    w_misalign = (HADDR[1:0] != 2'b00);
            default: w_misalign = 1'b0;
        endcase
    end

    // Read source: new address on a zero-wait accept, held address at the end of wait states;
    // forward the store committing on the same edge when it hits the same word.
    always_comb begin
        w_src_idx  = r_idx;
        w_src_lo   = r_lo;
        w_src_size = r_size;
        if (w_accept) begin
            w_src_idx  = w_offset[ADDR_W+1:2];
            w_src_lo   = HADDR[1:0];
            w_src_size = HSIZE;
        end else begin
            w_src_idx  = r_idx;
            w_src_lo   = r_lo;
            w_src_size = r_size;
        end
        if (w_commit && (w_src_idx == r_idx)) begin
            w_src_word = w_merged;
        end else begin
            w_src_word = r_mem[w_src_idx];
        end
    end

    // Next-state and wait-counter logic.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = S_DATA;
                end else begin
                    w_next     = S_WAIT;
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_ERR1: begin
                w_next = S_ERR2;
            end
            default: begin
                if (!w_accept) begin
                    w_next = S_IDLE;
                end else if (w_err) begin
                    w_next = S_ERR1;
                end else if (WAIT_STATES == 0) begin
                    w_next = S_DATA;
                end else begin
                    w_next     = S_WAIT;
                    w_cnt_next = 4'(WAIT_STATES - 1);
                end
            end
        endcase
    end

    // Load data is captured on the edge entering the final (ready) data-phase cycle of a read.
    always_comb begin
        w_load = 1'b0;
        if (w_next == S_DATA) begin
            w_load = w_accept ? !HWRITE : !r_write;
        end else begin
            w_load = 1'b0;
        end
    end

    // Control state, registered bus responses and transfer attributes.
    always_ff @(posedge CLK) begin
        if (RES) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_idx       <= {ADDR_W{1'b0}};
            r_lo        <= 2'b00;
            r_size      <= 3'd0;
            r_write     <= 1'b0;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_hrdata    <= 32'h0000_0000;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_next;
            r_hreadyout <= !((w_next == S_WAIT) || (w_next == S_ERR1));
            r_hresp     <= (w_next == S_ERR1) || (w_next == S_ERR2);
            if (w_accept) begin
                r_idx   <= w_offset[ADDR_W+1:2];
                r_lo    <= HADDR[1:0];
                r_size  <= HSIZE;
                r_write <= HWRITE && !w_err;
            end
            if (w_load) begin
                r_hrdata <= f_extract(w_src_word, w_src_size, w_src_lo);
            end
        end
    end

    // SRAM byte-lane write; contents are deliberately not cleared by reset.
    always_ff @(posedge CLK) begin
        if (w_commit) begin
            r_mem[r_idx] <= w_merged;
        end
    end

    assign HREADYOUT = r_hreadyout;
    assign HRESP     = r_hresp;
    assign HRDATA_D  = r_hrdata;

endmodule
